// File: rtl/ace_snoop_scheduler.sv
// Round-robin scheduler that issues ACE snoops for one granted coherent read at a time,
// merges the CR responses, and hands a completion record downstream.
module ace_snoop_scheduler #(
  parameter int unsigned NumMst = 4,
  localparam int unsigned IdxW = (NumMst > 1) ? $clog2(NumMst) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NumMst-1:0]     req_valid_i,
  input  logic [NumMst-1:0]     req_snooping_i,
  input  logic [NumMst-1:0]     req_illegal_i,
  input  logic [4*NumMst-1:0]   req_snoop_trs_i,
  output logic [NumMst-1:0]     req_ready_o,
  output logic [NumMst-1:0]     ac_valid_o,
  input  logic [NumMst-1:0]     ac_ready_i,
  output logic [3:0]            ac_snoop_o,
  input  logic [NumMst-1:0]     cr_valid_i,
  input  logic [5*NumMst-1:0]   cr_resp_i,
  output logic [NumMst-1:0]     cr_ready_o,
  output logic                  done_valid_o,
  input  logic                  done_ready_i,
  output logic [IdxW-1:0]       done_idx_o,
  output logic                  done_snooped_o,
  output logic                  done_illegal_o,
  output logic [4:0]            done_resp_o
);

  typedef enum logic [1:0] {StIdle, StSnoop, StDone} state_e;

  localparam logic [NumMst-1:0] OneM = NumMst'(1);

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [3:0]          snoop_trs_q, snoop_trs_d;
  logic                snooping_q, snooping_d;
  logic                illegal_q, illegal_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NumMst-1:0]   tgt_q, tgt_d;
  logic [NumMst-1:0]   ac_sent_q, ac_sent_d;
  logic [NumMst-1:0]   cr_rcvd_q, cr_rcvd_d;
  logic [4:0]          resp_acc_q, resp_acc_d;

  logic                grant_found;
  logic [IdxW-1:0]     grant_idx;

  // First valid requester at or above rr_ptr, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned i = 0; i < NumMst; i++) begin
      if (!grant_found && req_valid_i[IdxW'((rr_ptr_q + i) % NumMst)]) begin
        grant_found = 1'b1;
        grant_idx   = IdxW'((rr_ptr_q + i) % NumMst);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    snoop_trs_d    = snoop_trs_q;
    snooping_d     = snooping_q;
    illegal_d      = illegal_q;
    rr_ptr_d       = rr_ptr_q;
    tgt_d          = tgt_q;
    ac_sent_d      = ac_sent_q;
    cr_rcvd_d      = cr_rcvd_q;
    resp_acc_d     = resp_acc_q;
    req_ready_o    = '0;
    ac_valid_o     = '0;
    ac_snoop_o     = '0;
    cr_ready_o     = '0;
    done_valid_o   = 1'b0;
    done_idx_o     = '0;
    done_snooped_o = 1'b0;
    done_illegal_o = 1'b0;
    done_resp_o    = '0;

    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          idx_d       = grant_idx;
          snoop_trs_d = req_snoop_trs_i[4*grant_idx +: 4];
          snooping_d  = req_snooping_i[grant_idx];
          illegal_d   = req_illegal_i[grant_idx];
          rr_ptr_d    = (grant_idx == IdxW'(NumMst - 1)) ? '0 : grant_idx + IdxW'(1);
          ac_sent_d   = '0;
          cr_rcvd_d   = '0;
          resp_acc_d  = '0;
          tgt_d       = ~(OneM << grant_idx);
          // Illegal wins over snooping; a lone master has nobody to snoop.
          if (req_illegal_i[grant_idx] || !req_snooping_i[grant_idx] || (tgt_d == '0)) begin
            state_d = StDone;
          end else begin
            state_d = StSnoop;
          end
        end
      end
      StSnoop: begin
        ac_valid_o = tgt_q & ~ac_sent_q;
        ac_snoop_o = (|ac_valid_o) ? snoop_trs_q : 4'b0000;
        // CR is only taken once the AC handshake is already registered.
        cr_ready_o = tgt_q & ac_sent_q & ~cr_rcvd_q;
        ac_sent_d  = ac_sent_q | (ac_valid_o & ac_ready_i);
        cr_rcvd_d  = cr_rcvd_q | (cr_ready_o & cr_valid_i);
        for (int unsigned m = 0; m < NumMst; m++) begin
          if (cr_ready_o[m] && cr_valid_i[m]) begin
            resp_acc_d = resp_acc_d | cr_resp_i[5*m +: 5];
          end
        end
        if (&(cr_rcvd_d | ~tgt_q)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done_valid_o   = 1'b1;
        done_idx_o     = idx_q;
        done_snooped_o = snooping_q & ~illegal_q & (|tgt_q);
        done_illegal_o = illegal_q;
        done_resp_o    = resp_acc_q;
        if (done_ready_i) begin
          req_ready_o = OneM << idx_q;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      snoop_trs_q <= '0;
      snooping_q  <= 1'b0;
      illegal_q   <= 1'b0;
      rr_ptr_q    <= '0;
      tgt_q       <= '0;
      ac_sent_q   <= '0;
      cr_rcvd_q   <= '0;
      resp_acc_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      snoop_trs_q <= snoop_trs_d;
      snooping_q  <= snooping_d;
      illegal_q   <= illegal_d;
      rr_ptr_q    <= rr_ptr_d;
      tgt_q       <= tgt_d;
      ac_sent_q   <= ac_sent_d;
      cr_rcvd_q   <= cr_rcvd_d;
      resp_acc_q  <= resp_acc_d;
    end
  end

endmodule

// File: tb/tb_ace_snoop_scheduler.sv
// Bench for ace_snoop_scheduler: directed scenarios plus a randomized run scored against
// a round-robin / OR-merge reference model.
module tb_ace_snoop_scheduler;
  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           rst_i;
  logic [N-1:0]   req_valid_i, req_snooping_i, req_illegal_i;
  logic [4*N-1:0] req_snoop_trs_i;
  logic [N-1:0]   req_ready_o, ac_valid_o, ac_ready_i, cr_valid_i, cr_ready_o;
  logic [3:0]     ac_snoop_o;
  logic [5*N-1:0] cr_resp_i;
  logic           done_valid_o, done_ready_i, done_snooped_o, done_illegal_o;
  logic [1:0]     done_idx_o;
  logic [4:0]     done_resp_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ace_snoop_scheduler #(.NumMst(N)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_snooping_i(req_snooping_i),
    .req_illegal_i(req_illegal_i), .req_snoop_trs_i(req_snoop_trs_i),
    .req_ready_o(req_ready_o), .ac_valid_o(ac_valid_o), .ac_ready_i(ac_ready_i),
    .ac_snoop_o(ac_snoop_o), .cr_valid_i(cr_valid_i), .cr_resp_i(cr_resp_i),
    .cr_ready_o(cr_ready_o), .done_valid_o(done_valid_o), .done_ready_i(done_ready_i),
    .done_idx_o(done_idx_o), .done_snooped_o(done_snooped_o),
    .done_illegal_o(done_illegal_o), .done_resp_o(done_resp_o)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by %0t, want finish earlier", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid_i = '0; req_snooping_i = '0; req_illegal_i = '0; req_snoop_trs_i = '0;
    ac_ready_i = '0; cr_valid_i = '0; cr_resp_i = '0; done_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    vectors++;
    if ({ac_valid_o, cr_ready_o, req_ready_o} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_vld: got %h want 000", {ac_valid_o, cr_ready_o, req_ready_o});
    end
    vectors++;
    if ({done_valid_o, done_idx_o, done_snooped_o, done_illegal_o, done_resp_o, ac_snoop_o}
        !== 14'h0) begin
      miscompares++;
      $display("FAIL reset_done: got %h want 0",
               {done_valid_o, done_idx_o, done_snooped_o, done_illegal_o, done_resp_o, ac_snoop_o});
    end
    tick();
  endtask

  task automatic test_non_snoop();
    do_reset();
    req_valid_i = 4'b0100; req_snoop_trs_i = '0; done_ready_i = 1'b1;
    @(negedge clk);
    vectors++;
    if ({done_valid_o, ac_valid_o, req_ready_o} !== 9'h0) begin
      miscompares++;
      $display("FAIL ns_c0: got %h want 0", {done_valid_o, ac_valid_o, req_ready_o});
    end
    tick();
    @(negedge clk);
    vectors++;
    if ({done_valid_o, done_idx_o, done_snooped_o, done_resp_o} !== {1'b1, 2'd2, 1'b0, 5'b0}) begin
      miscompares++;
      $display("FAIL ns_done: got %h want %h", {done_valid_o, done_idx_o, done_snooped_o,
               done_resp_o}, {1'b1, 2'd2, 1'b0, 5'b0});
    end
    vectors++;
    if ({req_ready_o, ac_valid_o} !== {4'b0100, 4'b0000}) begin
      miscompares++;
      $display("FAIL ns_rdy: got %b want 01000000", {req_ready_o, ac_valid_o});
    end
    tick();
    req_valid_i = '0;
    @(negedge clk);
    vectors++;
    if ({done_valid_o, req_ready_o, ac_valid_o} !== 9'h0) begin
      miscompares++;
      $display("FAIL ns_c2: got %h want 0", {done_valid_o, req_ready_o, ac_valid_o});
    end
    tick();
  endtask

  task automatic test_snoop_basic();
    do_reset();
    req_valid_i = 4'b0001; req_snooping_i = 4'b0001; req_snoop_trs_i = 16'h0001;
    ac_ready_i = 4'hF; cr_valid_i = 4'hF; done_ready_i = 1'b1;
    cr_resp_i = {5'b00000, 5'b01000, 5'b00001, 5'b00000};
    @(negedge clk);
    vectors++;
    if (ac_valid_o !== 4'b0000) begin
      miscompares++; $display("FAIL sb_c0: ac_valid got %b want 0000", ac_valid_o);
    end
    tick();
    @(negedge clk);
    vectors++;
    if ({ac_valid_o, ac_snoop_o, cr_ready_o} !== {4'b1110, 4'b0001, 4'b0000}) begin
      miscompares++;
      $display("FAIL sb_ac: got %b want 111000010000", {ac_valid_o, ac_snoop_o, cr_ready_o});
    end
    tick();
    @(negedge clk);
    vectors++;
    if ({ac_valid_o, cr_ready_o, done_valid_o} !== {4'b0000, 4'b1110, 1'b0}) begin
      miscompares++;
      $display("FAIL sb_cr: got %b want 000011100", {ac_valid_o, cr_ready_o, done_valid_o});
    end
    tick();
    @(negedge clk);
    vectors++;
    if ({done_valid_o, done_idx_o, done_snooped_o, done_resp_o, req_ready_o}
        !== {1'b1, 2'd0, 1'b1, 5'b01001, 4'b0001}) begin
      miscompares++;
      $display("FAIL sb_done: got %b want %b", {done_valid_o, done_idx_o, done_snooped_o,
               done_resp_o, req_ready_o}, {1'b1, 2'd0, 1'b1, 5'b01001, 4'b0001});
    end
    tick();
    idle_inputs();
    @(negedge clk);
    vectors++;
    if (done_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL sb_after: done_valid got %b want 0", done_valid_o);
    end
    tick();
  endtask

  task automatic test_staggered();
    do_reset();
    req_valid_i = 4'b0001; req_snooping_i = 4'b0001; req_snoop_trs_i = 16'h0001;
    ac_ready_i = 4'b0111; cr_valid_i = 4'hF; done_ready_i = 1'b1;
    cr_resp_i = {5'b10000, 5'b00100, 5'b00010, 5'b00000};
    for (int k = 0; k < 8; k++) begin
      if (k == 5) ac_ready_i = 4'hF;
      @(negedge clk);
      if (k >= 1 && k <= 5) begin
        vectors++;
        if ({ac_valid_o[3], cr_ready_o[3], done_valid_o} !== 3'b100) begin
          miscompares++;
          $display("FAIL stg_hold%0d: got %b want 100", k,
                   {ac_valid_o[3], cr_ready_o[3], done_valid_o});
        end
      end
      if (k == 2) begin
        vectors++;
        if (cr_ready_o !== 4'b0110) begin
          miscompares++; $display("FAIL stg_cr12: got %b want 0110", cr_ready_o);
        end
      end
      if (k == 6) begin
        vectors++;
        if ({ac_valid_o, cr_ready_o, done_valid_o} !== {4'b0000, 4'b1000, 1'b0}) begin
          miscompares++;
          $display("FAIL stg_cr3: got %b want 000010000", {ac_valid_o, cr_ready_o, done_valid_o});
        end
      end
      if (k == 7) begin
        vectors++;
        if ({done_valid_o, done_resp_o, req_ready_o} !== {1'b1, 5'b10110, 4'b0001}) begin
          miscompares++;
          $display("FAIL stg_done: got %b want 1101100001", {done_valid_o, done_resp_o, req_ready_o});
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_round_robin();
    int exp_idx;
    int got;
    do_reset();
    req_valid_i = 4'hF; done_ready_i = 1'b1;
    exp_idx = 0;
    got = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      @(negedge clk);
      if (done_valid_o) begin
        vectors++;
        if ({done_idx_o, req_ready_o} !== {2'(exp_idx), 4'(1 << exp_idx)}) begin
          miscompares++;
          $display("FAIL rr_grant%0d: got idx %0d rdy %b want idx %0d", got, done_idx_o,
                   req_ready_o, exp_idx);
        end
        exp_idx = (exp_idx + 1) % N;
        got++;
      end
      tick();
    end
    vectors++;
    if (got != 5) begin
      miscompares++; $display("FAIL rr_count: got %0d grants want 5", got);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_illegal();
    do_reset();
    req_valid_i = 4'b0010; req_illegal_i = 4'b0010; req_snooping_i = 4'b0010;
    req_snoop_trs_i = 16'h0010; ac_ready_i = 4'hF; done_ready_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) done_ready_i = 1'b1;
      if (k == 5) idle_inputs();
      @(negedge clk);
      vectors++;
      if (ac_valid_o !== 4'b0000) begin
        miscompares++; $display("FAIL ill_ac%0d: got %b want 0000", k, ac_valid_o);
      end
      if (k >= 1 && k <= 4) begin
        vectors++;
        if ({done_valid_o, done_illegal_o, done_idx_o, done_snooped_o, req_ready_o}
            !== {1'b1, 1'b1, 2'd1, 1'b0, (k == 4) ? 4'b0010 : 4'b0000}) begin
          miscompares++;
          $display("FAIL ill_done%0d: got %b", k, {done_valid_o, done_illegal_o, done_idx_o,
                   done_snooped_o, req_ready_o});
        end
      end
      if (k == 5) begin
        vectors++;
        if ({done_valid_o, req_ready_o} !== 5'b0) begin
          miscompares++; $display("FAIL ill_after: got %b want 00000", {done_valid_o, req_ready_o});
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_abort();
    do_reset();
    req_valid_i = 4'b0001; req_snooping_i = 4'b0001; req_snoop_trs_i = 16'h0002;
    ac_ready_i = 4'hF; cr_valid_i = 4'b0010; done_ready_i = 1'b1;
    cr_resp_i = {5'b0, 5'b0, 5'b00100, 5'b0};
    tick();
    tick();
    tick();
    @(negedge clk);
    vectors++;
    if ({cr_ready_o, req_ready_o} !== {4'b1100, 4'b0000}) begin
      miscompares++; $display("FAIL ab_pre: got %b want 11000000", {cr_ready_o, req_ready_o});
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    cr_valid_i = 4'hF;
    cr_resp_i = {5'b0, 5'b0, 5'b00001, 5'b0};
    @(negedge clk);
    vectors++;
    if ({ac_valid_o, cr_ready_o, req_ready_o, done_valid_o, done_resp_o, ac_snoop_o} !== 26'h0) begin
      miscompares++;
      $display("FAIL ab_zero: got %h want 0", {ac_valid_o, cr_ready_o, req_ready_o,
               done_valid_o, done_resp_o, ac_snoop_o});
    end
    tick();
    tick();
    tick();
    @(negedge clk);
    vectors++;
    if ({done_valid_o, done_resp_o, req_ready_o} !== {1'b1, 5'b00001, 4'b0001}) begin
      miscompares++;
      $display("FAIL ab_redo: got %b want 1000010001", {done_valid_o, done_resp_o, req_ready_o});
    end
    tick();
    idle_inputs();
    tick();
  endtask

  function automatic int pick(int rr, logic [N-1:0] act);
    for (int i = 0; i < N; i++) begin
      if (act[(rr + i) % N]) return (rr + i) % N;
    end
    return 0;
  endfunction

  task automatic test_random();
    logic [N-1:0] active, snp_a, ill_a, ac_mask, cr_mask, exp_tgt;
    logic [3:0]   trs_a [N];
    logic [4:0]   acc;
    logic         exp_snp;
    int rr, exp_idx, ntx, wait_cyc;
    bit completed;
    do_reset();
    rr = 0; ntx = 0; wait_cyc = 0;
    active = 4'hF;
    for (int m = 0; m < N; m++) begin
      snp_a[m] = 1'($urandom_range(0, 1));
      ill_a[m] = ($urandom_range(0, 3) == 0);
      trs_a[m] = 4'($urandom);
    end
    exp_idx = pick(rr, active);
    ac_mask = '0; cr_mask = '0; acc = '0;
    for (int c = 0; c < 4000 && ntx < 60; c++) begin
      completed = 1'b0;
      req_valid_i = active; req_snooping_i = snp_a; req_illegal_i = ill_a;
      for (int m = 0; m < N; m++) req_snoop_trs_i[4*m +: 4] = trs_a[m];
      ac_ready_i = 4'($urandom); cr_valid_i = 4'($urandom);
      cr_resp_i = 20'($urandom); done_ready_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      for (int m = 0; m < N; m++) begin
        if (cr_valid_i[m] && cr_ready_o[m]) begin
          vectors++;
          if (!ac_mask[m] || m == exp_idx || cr_mask[m]) begin
            miscompares++;
            $display("FAIL rnd_cr_order: master %0d got cr hs with ac_mask %b want earlier ac",
                     m, ac_mask);
          end
          cr_mask[m] = 1'b1;
          acc = acc | cr_resp_i[5*m +: 5];
        end
      end
      for (int m = 0; m < N; m++) begin
        if (ac_valid_o[m] && ac_ready_i[m]) begin
          vectors++;
          if (ac_snoop_o !== trs_a[exp_idx] || m == exp_idx) begin
            miscompares++;
            $display("FAIL rnd_ac: master %0d got snoop %h want %h", m, ac_snoop_o, trs_a[exp_idx]);
          end
          ac_mask[m] = 1'b1;
        end
      end
      if (done_valid_o && done_ready_i) begin
        exp_snp = snp_a[exp_idx] & ~ill_a[exp_idx];
        exp_tgt = exp_snp ? (4'hF & ~4'(1 << exp_idx)) : 4'h0;
        vectors++;
        if ({done_idx_o, done_illegal_o, done_snooped_o, done_resp_o, req_ready_o}
            !== {2'(exp_idx), ill_a[exp_idx], exp_snp, acc, 4'(1 << exp_idx)}) begin
          miscompares++;
          $display("FAIL rnd_done%0d: got %b want %b", ntx, {done_idx_o, done_illegal_o,
                   done_snooped_o, done_resp_o, req_ready_o},
                   {2'(exp_idx), ill_a[exp_idx], exp_snp, acc, 4'(1 << exp_idx)});
        end
        vectors++;
        if ({ac_mask, cr_mask} !== {exp_tgt, exp_tgt}) begin
          miscompares++;
          $display("FAIL rnd_tgt%0d: got ac %b cr %b want %b", ntx, ac_mask, cr_mask, exp_tgt);
        end
        ntx++;
        rr = (exp_idx + 1) % N;
        completed = 1'b1;
        wait_cyc = 0;
      end else begin
        wait_cyc++;
      end
      if (wait_cyc > 100) begin
        vectors++;
        miscompares++;
        $display("FAIL rnd_timeout: got no completion in 100 cycles want one");
        break;
      end
      tick();
      if (completed) begin
        snp_a[exp_idx] = 1'($urandom_range(0, 1));
        ill_a[exp_idx] = ($urandom_range(0, 3) == 0);
        trs_a[exp_idx] = 4'($urandom);
        if (ntx % 8 == 0) active = 4'($urandom_range(1, 15));
        exp_idx = pick(rr, active);
        ac_mask = '0; cr_mask = '0; acc = '0;
      end
    end
    vectors++;
    if (ntx != 60) begin
      miscompares++; $display("FAIL rnd_count: got %0d transactions want 60", ntx);
    end
    idle_inputs();
  endtask

  initial begin
    rst_i = 1'b1;
    idle_inputs();
    test_reset();
    test_non_snoop();
    test_snoop_basic();
    test_staggered();
    test_round_robin();
    test_illegal();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
